demux_sel_sequencer: RTL and testbench
======================================

# demux_sel_sequencer

Generates the two select lines for `demux_1_to_4` from a raw push-button, or from a free-running scan timer. Output index `{o_sel_1, o_sel_2}` steps 0→1→2→3→0. In manual mode, each debounced button press advances the index by one. In auto mode, the index also advances once every `SCAN_PERIOD` cycles. The block sits directly upstream of the demux; `o_sel_1`/`o_sel_2` wire straight to `i_sel_1`/`i_sel_2`.

## Interface

- `DEBOUNCE_LIMIT`, default 250000: number of consecutive stable cycles required to accept a switch level change. Legal range ≥ 2.
- `SCAN_PERIOD`, default 25000000: auto-mode step interval, in cycles. Legal range ≥ 2.
- `i_clk`  input  1  system clock; all state changes on its rising edge.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_switch`  input  1  raw, bouncy, asynchronous push-button, active high.
- `i_mode`  input  1  asynchronous level: 0 = manual, 1 = auto-scan.
- `o_sel_1`  output  1  select MSB (`index[1]`), to `demux_1_to_4.i_sel_1`.
- `o_sel_2`  output  1  select LSB (`index[0]`), to `demux_1_to_4.i_sel_2`.
- `o_step`  output  1  one-cycle pulse, high in the cycle after the index changes.

## Operation

- **Reset (`i_rst_n` low):**
  - Asserting reset immediately forces index = 0 and `o_sel_1 = o_sel_2 = o_step = 0`.
  - Synchronizers, debounced state, debounce counter and scan counter all clear to 0.
  - Reset asserted mid-debounce or mid-scan discards all progress.
- **Synchronizers:** `i_switch` and `i_mode` each pass through a 2-flop synchronizer before use.
- **Debounce:**
  - Counter `cnt` tracks how long the synchronized switch has differed from the debounced state `db`.
  - While synced ≠ `db`, `cnt` increments.
  - When `cnt == DEBOUNCE_LIMIT-1` and the mismatch persists, `db` takes the synced value and `cnt` clears.
  - Any cycle with synced == `db` clears `cnt`.
- **Press:** `press = db & ~db_q`, a rising-edge detect. Releases never step the index.
- **Scan counter:**
  - Held at 0 while synced mode = 0.
  - Otherwise counts 0..`SCAN_PERIOD-1` and wraps.
  - `tick` is asserted when the count equals `SCAN_PERIOD-1`.
- **Advance condition:** `advance = press | (mode & tick)`.
  - On `advance`, index ← index + 1 mod 4 (3 wraps to 0), and `o_step` is registered high for one cycle.
- **Simultaneous events:**
  - Press and tick in the same cycle advance the index by exactly one.
  - A press in auto mode advances the index and restarts the scan counter at 0.
- **Mode change:**
  - Auto→manual clears the scan counter; the index is held.
  - Manual→auto starts counting from 0.

## Timing

- **Switch path:** `i_switch` goes high and is first sampled at edge 1, then held. `db` rises at edge `DEBOUNCE_LIMIT+2`, and the index updates at edge `DEBOUNCE_LIMIT+3`. `o_step` is high for the cycle following that edge.
- **Glitch rejection:** a switch pulse lasting fewer than `DEBOUNCE_LIMIT` synced cycles produces no step.
- **Auto mode:** `i_mode` goes high and is first sampled at edge 1. The first index update occurs at edge `SCAN_PERIOD+2`, then every `SCAN_PERIOD` edges after that.
- **Output registers:** `o_sel_*` are registered and glitch-free, and change only on a rising edge of `i_clk`.
- **Counter widths:**
  - Debounce counter: `$clog2(DEBOUNCE_LIMIT)` bits.
  - Scan counter: `$clog2(SCAN_PERIOD)` bits.
  - Neither counter may overflow.

## Structure

- **Package `demux_seq_pkg`:**
  - `typedef logic [1:0] sel_idx_t`
  - `localparam int SEL_COUNT = 4`
  - Default values for `DEBOUNCE_LIMIT` and `SCAN_PERIOD`.
- **Sub-module `debounce_filter`:**
  - Contains the 2-flop synchronizer and debounce counter.
  - Parameter `DEBOUNCE_LIMIT`; ports `i_clk`, `i_rst_n`, `i_raw`, `o_level`.
  - Instantiated once, for `i_switch`.
- **Top level:** `i_mode` uses only a plain 2-flop synchronizer in the top module. Edge detect, scan counter and index register also live in the top.

## Test plan

All scenarios use `DEBOUNCE_LIMIT=4` and `SCAN_PERIOD=8`, with a 10-unit clock period.

- **Reset:** drive `i_rst_n=0` mid-cycle → `o_sel_1=o_sel_2=o_step=0` immediately. Release reset and hold all inputs at 0 for 20 cycles → outputs stay 0.
- **Clean press:** `i_switch` high from edge 1, `i_mode=0` → `{o_sel_1,o_sel_2}` goes 00→01 at edge 7, with `o_step` high exactly one cycle. Release → no change. Four further clean presses → 10, 11, 00, 01 (wrap-around verified).
- **Bounce:** `i_switch` toggles 1,0,1,0,1 on successive cycles, then holds 1 → exactly one step. An isolated 3-cycle high pulse → no step.
- **Auto-scan:** `i_mode=1` from edge 1 → index steps at edges 10, 18, 26, 34, giving 01, 10, 11, 00. Drive `i_mode=0` → index holds indefinitely.
- **Collision:** in auto mode, arrange for a debounced press to land on the same cycle as `tick` → index advances by one only, and the next auto step occurs 8 cycles later.
- **Reset mid-operation:** assert reset at scan count 5 with index = 2 → index = 0. After release in auto mode, the first step occurs `SCAN_PERIOD+2` edges later.

Source files
------------

// File: rtl/demux_sel_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// demux_seq_pkg
// Shared types and defaults for the demux select sequencer.
//   sel_idx_t              : 2-bit select index {sel_1, sel_2}
//   SEL_COUNT              : number of demux outputs addressed by the index
//   DEFAULT_DEBOUNCE_LIMIT : default stable-cycle count for the switch filter
//   DEFAULT_SCAN_PERIOD    : default auto-scan step interval in cycles
//   next_sel()             : index + 1, wrapping 3 -> 0
// -----------------------------------------------------------------------------
package demux_seq_pkg;

  typedef logic [1:0] sel_idx_t;

  localparam int SEL_COUNT              = 4;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int DEFAULT_SCAN_PERIOD    = 25000000;

  function automatic sel_idx_t next_sel(input sel_idx_t cur);
    return sel_idx_t'((int'(cur) + 1) % SEL_COUNT);
  endfunction

endpackage

// File: rtl/demux_sel_sequencer_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Two-flop synchronizer followed by a debounce counter. The filtered level
// only follows the synchronized input after it has differed from the current
// filtered level for DEBOUNCE_LIMIT consecutive cycles.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_raw    : raw asynchronous input
//   o_level  : debounced level
// -----------------------------------------------------------------------------
module debounce_filter
  import demux_seq_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          meta_q;
  logic          sync_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= i_raw;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  // cnt counts mismatch cycles already seen; on the LIMIT-th consecutive
  // mismatch the level is accepted, so cnt never needs to exceed LIMIT-1.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign o_level = db_q;

endmodule

// File: rtl/demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sel_sequencer
// Drives the two select lines of demux_1_to_4. The index steps 0->1->2->3->0
// on each debounced button press, and additionally every SCAN_PERIOD cycles
// while auto mode is selected.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_switch : raw push-button, active high
//   i_mode   : 0 = manual, 1 = auto-scan (asynchronous level)
//   o_sel_1  : index[1], to demux_1_to_4.i_sel_1
//   o_sel_2  : index[0], to demux_1_to_4.i_sel_2
//   o_step   : one-cycle pulse in the cycle after the index changes
// -----------------------------------------------------------------------------
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int SCAN_PERIOD    = DEFAULT_SCAN_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch,
  input  logic i_mode,
  output logic o_sel_1,
  output logic o_sel_2,
  output logic o_step
);

  localparam int SW = $clog2(SCAN_PERIOD);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

  logic          mode_meta_q;
  logic          mode_sync_q;
  logic          db_level;
  logic          db_level_q;
  logic          press;
  logic          tick;
  logic          advance;
  logic [SW-1:0] scan_q;
  logic [SW-1:0] scan_d;
  sel_idx_t      idx_q;
  sel_idx_t      idx_d;
  logic          step_q;
  logic          step_d;

  debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_switch_db (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_switch),
    .o_level (db_level)
  );

  assign press   = db_level & ~db_level_q;
  assign tick    = (scan_q == SCAN_LAST);
  assign advance = press | (mode_sync_q & tick);

  // Any advance (tick wrap or press) restarts the scan interval, so a press
  // in auto mode pushes the next automatic step a full period out.
  always_comb begin
    scan_d = '0;
    idx_d  = idx_q;
    step_d = 1'b0;
    if (mode_sync_q && !advance) begin
      scan_d = scan_q + SW'(1);
    end
    if (advance) begin
      idx_d  = next_sel(idx_q);
      step_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      db_level_q  <= 1'b0;
      scan_q      <= '0;
      idx_q       <= '0;
      step_q      <= 1'b0;
    end else begin
      mode_meta_q <= i_mode;
      mode_sync_q <= mode_meta_q;
      db_level_q  <= db_level;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
    end
  end

  assign o_sel_1 = idx_q[1];
  assign o_sel_2 = idx_q[0];
  assign o_step  = step_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_sel_sequencer
// Scoreboard bench: a reference model predicts on which edge each index step
// happens and the resulting index; a monitor pops and compares whenever the
// DUT pulses o_step. Directed scenarios add fixed-timing checks.
// -----------------------------------------------------------------------------
module tb_demux_sel_sequencer;

  localparam int DB_LIMIT = 4;
  localparam int SCAN_P   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw    = 1'b0;
  logic mode  = 1'b0;
  logic sel_1;
  logic sel_2;
  logic step;
  logic [1:0] sel;

  assign sel = {sel_1, sel_2};

  demux_sel_sequencer #(
    .DEBOUNCE_LIMIT(DB_LIMIT),
    .SCAN_PERIOD   (SCAN_P)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_switch (sw),
    .i_mode   (mode),
    .o_sel_1  (sel_1),
    .o_sel_2  (sel_2),
    .o_step   (step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int edge_no;
    int idx;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int   edge_n  = 0;
  int   m_idx   = 0;
  int   since   = 0;
  logic m_db    = 1'b0;
  logic pend    = 1'b0;
  logic sw_p0   = 1'b0;
  logic sw_p1   = 1'b0;
  logic md_p0   = 1'b0;
  logic md_p1   = 1'b0;
  logic sw_seen = 1'b0;
  logic md_seen = 1'b0;
  logic m_step  = 1'b0;
  logic flip    = 1'b0;
  logic win_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: inputs reach the logic two edges after being sampled. The
  // debounced level flips once the last DB_LIMIT seen values all disagree
  // with it; a rising flip steps the index one edge later. In auto mode a
  // step also happens SCAN_P edges after the last restart, where a restart
  // is any step or any edge with manual mode seen.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_n = 0;
        m_idx  = 0;
        since  = 0;
        m_db   = 1'b0;
        pend   = 1'b0;
        sw_p0  = 1'b0;
        sw_p1  = 1'b0;
        md_p0  = 1'b0;
        md_p1  = 1'b0;
        win_q.delete();
        sb_q.delete();
      end else begin
        edge_n++;
        sw_seen = sw_p1;
        md_seen = md_p1;
        sw_p1   = sw_p0;
        sw_p0   = sw;
        md_p1   = md_p0;
        md_p0   = mode;
        since++;
        m_step = pend || (md_seen && since == SCAN_P);
        pend   = 1'b0;
        win_q.push_back(sw_seen);
        if (win_q.size() > DB_LIMIT) void'(win_q.pop_front());
        flip = (win_q.size() == DB_LIMIT);
        foreach (win_q[i]) if (win_q[i] == m_db) flip = 1'b0;
        if (flip) begin
          m_db = ~m_db;
          if (m_db) pend = 1'b1;
        end
        if (m_step) begin
          m_idx = (m_idx + 1) % 4;
          sb_q.push_back('{edge_no: edge_n, idx: m_idx});
        end
        if (m_step || !md_seen) since = 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (step) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step_unexpected edge=%0d sel=%0d", edge_n, sel);
          end else begin
            e = sb_q.pop_front();
            check("step_edge", edge_n, e.edge_no);
            check("step_sel", int'(sel), e.idx);
          end
        end
        if (sb_q.size() > 0 && sb_q[0].edge_no < edge_n) begin
          checks++;
          errors++;
          $display("FAIL step_missing expected_edge=%0d now=%0d", sb_q[0].edge_no, edge_n);
          void'(sb_q.pop_front());
        end
        check("sel_track", int'(sel), m_idx);
      end
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n < n) begin
      $display("FAIL wait_edge timeout target=%0d now=%0d", n, edge_n);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
    end
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks the outputs clear at
  // once, then releases on the next negedge so the next posedge is edge 1.
  task automatic do_reset(input logic sw_v, input logic mode_v);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel", int'(sel), 0);
    check("rst_step", int'(step), 0);
    @(negedge clk);
    sw    = sw_v;
    mode  = mode_v;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [4:0] pat;

    // Reset and idle
    #12;
    check("por_sel", int'(sel), 0);
    check("por_step", int'(step), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_sel", int'(sel), 0);
    check("idle_step", int'(step), 0);

    // Clean press
    do_reset(1'b1, 1'b0);
    wait_edge(6);
    check("press_e6_step", int'(step), 0);
    check("press_e6_sel", int'(sel), 0);
    wait_edge(7);
    check("press_e7_step", int'(step), 1);
    check("press_e7_sel", int'(sel), 1);
    wait_edge(8);
    check("press_e8_step", int'(step), 0);
    wait_edge(10);
    sw = 1'b0;
    wait_edge(22);
    check("release_sel", int'(sel), 1);
    for (int k = 0; k < 4; k++) begin
      sw = 1'b1;
      repeat (10) @(negedge clk);
      sw = 1'b0;
      repeat (10) @(negedge clk);
      check("press_wrap", int'(sel), (2 + k) % 4);
    end

    // Bounce then hold: exactly one step
    base = int'(sel);
    pat  = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      sw = pat[i];
      @(negedge clk);
    end
    sw = 1'b1;
    repeat (12) @(negedge clk);
    sw = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_one", int'(sel), (base + 1) % 4);

    // Short glitch: no step
    base = int'(sel);
    sw = 1'b1;
    repeat (3) @(negedge clk);
    sw = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_none", int'(sel), base);

    // Auto scan
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_edge(9 + 8 * k);
      check("auto_pre_step", int'(step), 0);
      wait_edge(10 + 8 * k);
      check("auto_step", int'(step), 1);
      check("auto_sel", int'(sel), (k + 1) % 4);
    end
    mode = 1'b0;
    repeat (40) @(negedge clk);
    check("manual_hold", int'(sel), 0);

    // Press landing on a tick
    do_reset(1'b0, 1'b1);
    wait_edge(11);
    sw = 1'b1;
    wait_edge(17);
    check("coll_pre_sel", int'(sel), 1);
    wait_edge(18);
    check("coll_step", int'(step), 1);
    check("coll_sel", int'(sel), 2);
    wait_edge(19);
    check("coll_post_step", int'(step), 0);
    wait_edge(20);
    sw = 1'b0;
    wait_edge(25);
    check("coll_gap_sel", int'(sel), 2);
    check("coll_gap_step", int'(step), 0);
    wait_edge(26);
    check("coll_next_step", int'(step), 1);
    check("coll_next_sel", int'(sel), 3);

    // Reset mid-scan with index 2
    do_reset(1'b0, 1'b1);
    wait_edge(23);
    check("mid_sel_before", int'(sel), 2);
    do_reset(1'b0, 1'b1);
    wait_edge(9);
    check("mid_pre_step", int'(step), 0);
    check("mid_pre_sel", int'(sel), 0);
    wait_edge(10);
    check("mid_first_step", int'(step), 1);
    check("mid_first_sel", int'(sel), 1);

    // Randomized switch and mode activity against the model
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      sw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    sw   = 1'b0;
    mode = 1'b0;
    repeat (30) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
